// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor: slice sizing,
// configuration check, the per-beat control record and the overflow rule.
package addsub_pkg;

  // Control half of a beat. The width-dependent half (partial sum and
  // remaining operand bits) travels alongside as WIDTH-wide vectors.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } beat_ctl_t;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage: ripples slice K of the operands with the incoming carry,
// registers the result, and owns its valid bit and its stall/ready decision.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int K      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  beat_ctl_t        ctl_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  input  logic             ready_i,
  output beat_ctl_t        ctl_o,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  localparam int SLICE = slice_w(WIDTH, STAGES);
  localparam int LSB   = K * SLICE;

  logic             valid_q;
  logic             carry_q;
  logic             carry_d;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             rc;

  // Empty or draining this cycle: either way the stage can take a new beat.
  assign ready_o = !valid_q || ready_i;

  always_comb begin
    sum_d = sum_i;
    rc    = ctl_i.carry;
    for (int i = 0; i < SLICE; i++) begin
      sum_d[LSB+i] = a_i[LSB+i] ^ b_i[LSB+i] ^ rc;
      rc           = (a_i[LSB+i] & b_i[LSB+i]) | (rc & (a_i[LSB+i] ^ b_i[LSB+i]));
    end
    carry_d = rc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (ready_o) begin
      valid_q <= ctl_i.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ready_o && ctl_i.valid) begin
      sum_q   <= sum_d;
      a_q     <= a_i;
      b_q     <= b_i;
      carry_q <= carry_d;
      a_msb_q <= ctl_i.a_msb;
      b_msb_q <= ctl_i.b_msb;
    end
  end

  always_comb begin
    ctl_o.valid = valid_q;
    ctl_o.carry = carry_q;
    ctl_o.a_msb = a_msb_q;
    ctl_o.b_msb = b_msb_q;
  end

  assign sum_o = sum_q;
  assign a_o   = a_q;
  assign b_o   = b_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple adder/subtractor with borrow-in, signed overflow and a
// fully back-pressured valid/ready handshake; one carry slice per stage.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carryout,
  output logic             overflow
);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_addsub: STAGES must be 1..WIDTH and divide WIDTH");
  end

  beat_ctl_t        ctl_in;
  logic [WIDTH-1:0] b_eff;

  beat_ctl_t        ctl_s [STAGES];
  logic [WIDTH-1:0] sum_s [STAGES];
  logic [WIDTH-1:0] a_s   [STAGES];
  logic [WIDTH-1:0] b_s   [STAGES];
  logic             rdy_s [STAGES];

  // Subtraction is a + ~b + ~borrow, so inversion happens once, at entry.
  always_comb begin
    b_eff        = sub ? ~b : b;
    ctl_in.valid = in_valid;
    ctl_in.carry = sub ? ~carryin : carryin;
    ctl_in.a_msb = a[WIDTH-1];
    ctl_in.b_msb = b_eff[WIDTH-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    beat_ctl_t        ctl_k;
    logic [WIDTH-1:0] sum_k;
    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;
    logic             rdy_k;

    if (k == 0) begin : g_first
      assign ctl_k = ctl_in;
      assign sum_k = '0;
      assign a_k   = a;
      assign b_k   = b_eff;
    end else begin : g_next
      assign ctl_k = ctl_s[k-1];
      assign sum_k = sum_s[k-1];
      assign a_k   = a_s[k-1];
      assign b_k   = b_s[k-1];
    end

    if (k == STAGES - 1) begin : g_last
      assign rdy_k = out_ready;
    end else begin : g_mid
      assign rdy_k = rdy_s[k+1];
    end

    addsub_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .K      (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .ctl_i   (ctl_k),
      .sum_i   (sum_k),
      .a_i     (a_k),
      .b_i     (b_k),
      .ready_o (rdy_s[k]),
      .ready_i (rdy_k),
      .ctl_o   (ctl_s[k]),
      .sum_o   (sum_s[k]),
      .a_o     (a_s[k]),
      .b_o     (b_s[k])
    );
  end

  // Data registers are not reset; outputs are masked so an idle port reads zero.
  assign in_ready  = rdy_s[0];
  assign out_valid = ctl_s[STAGES-1].valid;
  assign s         = out_valid ? sum_s[STAGES-1] : '0;
  assign carryout  = out_valid & ctl_s[STAGES-1].carry;
  assign overflow  = out_valid & signed_ovf(ctl_s[STAGES-1].a_msb,
                                            ctl_s[STAGES-1].b_msb,
                                            sum_s[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed vectors, stalls, reset in
// flight on a 32/4 instance, plus random sweeps on 8/1, 16/16 and 64/8.
`timescale 1ns/1ps
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance, WIDTH=32 STAGES=4 ----------------
  localparam int W  = 32;
  localparam int ST = 4;
  typedef logic [W+1:0] res_t;  // {overflow, carryout, s}

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carryin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         carryout;
  logic         overflow;

  pipelined_addsub #(.WIDTH(W), .STAGES(ST)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carryin   (carryin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .carryout  (carryout),
    .overflow  (overflow)
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic m);
    logic [W-1:0] be;
    logic         c0;
    logic [W:0]   full;
    logic [W:0]   wide;
    be   = m ? ~y : y;
    c0   = m ? ~c : c;
    full = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, c0};
    wide = {x[W-1], x} + {be[W-1], be} + {{W{1'b0}}, c0};
    return {wide[W] != wide[W-1], full[W], full[W-1:0]};
  endfunction

  res_t exp_q[$];
  int   stall_lo = -1;
  int   stall_hi = -1;
  bit   rnd_ready = 1'b0;
  bit   saw_bp = 1'b0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= stall_lo && cyc <= stall_hi) out_ready = 1'b0;
      else if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
    end
  end

  bit   hold_vld = 1'b0;
  res_t hold_val;
  always @(negedge clk) begin : mon_main
    res_t got;
    res_t e;
    got = {overflow, carryout, s};
    if (in_valid && !in_ready) saw_bp = 1'b1;
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) check_eq("hold_stable", got, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("result", got, e);
        end
      end
      hold_vld = out_valid && !out_ready;
      hold_val = got;
    end
  end

  // Returns right after the accepting clock edge, leaving in_valid high.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input logic m, input res_t e);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    rdy = 1'b0;
    #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    carryin = c;
    sub = m;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", rdy, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic m, input res_t e, input string tag);
    int lat;
    send(x, y, c, m, e);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq(tag, lat, ST);
    drain({tag, "_drain"});
  endtask

  initial begin : main
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    logic         m;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_s", s, '0);
    check_eq("rst_cout_ovf", {carryout, overflow}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);

    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, "lat_add_wrap");
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, "lat_add_ovf");
    directed(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, "lat_sub_borrow");
    directed(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, "lat_sub_ovf");
    directed(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFF}, "lat_sub_bin");

    // 16 back-to-back beats with out_ready low for cycles 6..9 of the stream
    saw_bp = 1'b0;
    stall_lo = cyc + 6;
    stall_hi = cyc + 9;
    for (int i = 0; i < 16; i++) begin
      x = $urandom(); y = $urandom(); c = 1'($urandom_range(0, 1)); m = 1'($urandom_range(0, 1));
      send(x, y, c, m, model(x, y, c, m));
    end
    #1 in_valid = 1'b0;
    drain("stream_drain");
    check_eq("in_ready_dropped", saw_bp, 1'b1);
    stall_lo = -1;
    stall_hi = -1;

    rnd_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      x = $urandom(); y = $urandom(); c = 1'($urandom_range(0, 1)); m = 1'($urandom_range(0, 1));
      if (i % 5 == 0) y = ~x;
      send(x, y, c, m, model(x, y, c, m));
    end
    #1 in_valid = 1'b0;
    drain("random_ready_drain");
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      x = $urandom(); y = $urandom();
      send(x, y, 1'b0, 1'b0, model(x, y, 1'b0, 1'b0));
    end
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_s", s, '0);
    check_eq("midrst_in_ready", in_ready, 1'b1);
    repeat (10) @(posedge clk);
    directed(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345_678A}, "post_rst");

    fork
      wait (g_sw[0].done && g_sw[1].done && g_sw[2].done);
      repeat (20000) @(posedge clk);
    join_any
    disable fork;
    check_eq("sweep_done", {g_sw[0].done, g_sw[1].done, g_sw[2].done}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- parameter sweep ----------------
  function automatic int sw_w(input int g);
    case (g)
      0:       return 8;
      1:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int sw_s(input int g);
    case (g)
      0:       return 1;
      1:       return 16;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int SW = sw_w(g);
    localparam int SS = sw_s(g);
    typedef logic [SW+1:0] r_t;

    logic          rst_s = 1'b1;
    logic          iv = 1'b0;
    logic          ir;
    logic [SW-1:0] xa = '0;
    logic [SW-1:0] xb = '0;
    logic          ci = 1'b0;
    logic          sb = 1'b0;
    logic          ov;
    logic          orr = 1'b1;
    logic [SW-1:0] so;
    logic          co;
    logic          of;
    bit            rnd = 1'b0;
    bit            done = 1'b0;
    r_t            q[$];
    string         pfx;

    pipelined_addsub #(.WIDTH(SW), .STAGES(SS)) u_sw (
      .clk       (clk),
      .rst       (rst_s),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (xa),
      .b         (xb),
      .carryin   (ci),
      .sub       (sb),
      .out_valid (ov),
      .out_ready (orr),
      .s         (so),
      .carryout  (co),
      .overflow  (of)
    );

    function automatic r_t mdl(input logic [SW-1:0] x, input logic [SW-1:0] y,
                               input logic c, input logic m);
      logic [SW-1:0] be;
      logic          c0;
      logic [SW:0]   full;
      logic [SW:0]   wide;
      be   = m ? ~y : y;
      c0   = m ? ~c : c;
      full = {1'b0, x} + {1'b0, be} + {{SW{1'b0}}, c0};
      wide = {x[SW-1], x} + {be[SW-1], be} + {{SW{1'b0}}, c0};
      return {wide[SW] != wide[SW-1], full[SW], full[SW-1:0]};
    endfunction

    always @(posedge clk) begin
      #1;
      orr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin : mon_sw
      r_t e;
      if (!rst_s && ov && orr) begin
        if (q.size() == 0) begin
          check_eq({pfx, "_spurious"}, ov, 1'b0);
        end else begin
          e = q.pop_front();
          check_eq({pfx, "_result"}, {of, co, so}, e);
        end
      end
    end

    task automatic put(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic c,
                       input logic m);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      rdy = 1'b0;
      #1;
      iv = 1'b1; xa = x; xb = y; ci = c; sb = m;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        rdy = ir;
        @(posedge clk);
        if (rdy) begin
          q.push_back(mdl(x, y, c, m));
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check_eq({pfx, "_accept_timeout"}, rdy, 1'b1);
    endtask

    initial begin : drv_sw
      int            lat;
      logic [63:0]   r1;
      logic [63:0]   r2;
      pfx = $sformatf("w%0d_s%0d", SW, SS);
      repeat (3) @(posedge clk);
      #1 rst_s = 1'b0;
      @(posedge clk);

      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      put(r1[SW-1:0], r2[SW-1:0], 1'b1, 1'b1);
      #1 iv = 1'b0;
      lat = 1;
      while (!ov && lat < 64) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check_eq({pfx, "_latency"}, lat, SS);
      @(posedge clk);

      rnd = 1'b1;
      for (int i = 0; i < 40; i++) begin
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        put(r1[SW-1:0], r2[SW-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      #1 iv = 1'b0;
      rnd = 1'b0;
      for (int n = 0; n < 400 && q.size() != 0; n++) @(posedge clk);
      check_eq({pfx, "_drain"}, q.size(), 0);
      done = 1'b1;
    end
  end

endmodule
